// File: rtl/neuron_pe.sv
// neuron_pe: streamed signed MAC neuron with bias, ReLU and saturating unsigned output.
// Define NEURON_PE_PIPE_EN to register the product before the accumulate (adds a DRAIN state).
module neuron_pe #(
    parameter int N_INPUTS = 784,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 32,
    parameter int SHIFT    = 8,
    parameter int OUT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   x_in,
    input  logic signed [WEIGHT_W-1:0] w_in,
    input  logic signed [ACC_W-1:0]    bias,
    output logic                       busy,
    output logic                       ready,
    output logic [OUT_W-1:0]           y_out,
    output logic                       ovf
);
    localparam int CNT_W = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1;
    localparam int P_W = DATA_W + WEIGHT_W;
    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, ACT, DONE} state_t;
    state_t state, state_nx;
    logic start_q, launch, go, last, mac_en, sat_o, clamp;
    logic [CNT_W-1:0] cnt;
    logic signed [P_W-1:0] prod, mac_p;
    logic signed [ACC_W-1:0] acc, addend, sat_sum, shifted;
    logic signed [ACC_W:0] sum;
    assign launch = start & ~start_q;
    assign go = launch && (state == IDLE || state == DONE);
    assign last = in_valid && cnt == CNT_W'(N_INPUTS - 1);
    assign prod = x_in * w_in;
    assign busy = state != IDLE && state != DONE;
`ifdef NEURON_PE_PIPE_EN
    localparam state_t AFTER_ACC = DRAIN;
    logic signed [P_W-1:0] prod_q;
    logic prod_v;
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            prod_v <= 1'b0;
        end else begin
            prod_q <= prod;
            prod_v <= state == ACCUM && in_valid;
        end
    end
    assign mac_en = prod_v;
    assign mac_p = prod_q;
`else
    localparam state_t AFTER_ACC = BIAS;
    assign mac_en = state == ACCUM && in_valid;
    assign mac_p = prod;
`endif
    always_comb begin
        addend = state == BIAS ? bias : ACC_W'(mac_p);
        sum = {acc[ACC_W-1], acc} + {addend[ACC_W-1], addend};
        sat_o = sum[ACC_W] ^ sum[ACC_W-1];
        sat_sum = sat_o ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
        shifted = acc >>> SHIFT;
        clamp = |shifted[ACC_W-1:OUT_W];
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = launch ? ACCUM : state;
            ACCUM:      state_nx = last ? AFTER_ACC : ACCUM;
            DRAIN:      state_nx = BIAS;
            BIAS:       state_nx = ACT;
            ACT:        state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0;
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            ready <= 1'b0;
            y_out <= '0;
        end else begin
            start_q <= start;
            ready <= state == DONE && !launch;
            if (go) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else begin
                if (mac_en || state == BIAS) begin
                    acc <= sat_sum;
                    ovf <= ovf | sat_o;
                end
                if (state == ACCUM && in_valid && !last) cnt <= cnt + CNT_W'(1);
                if (state == ACT) begin
                    y_out <= acc[ACC_W-1] ? '0 : (clamp ? '1 : shifted[OUT_W-1:0]);
                    ovf <= ovf | (!acc[ACC_W-1] && clamp);
                end
            end
        end
    end
endmodule
